// File: rtl/sm_pkg.sv
// rtl/sm_pkg.sv - shared defaults and helpers for the sign-magnitude accumulator
package sm_pkg;
   localparam int W_DEF     = 16;
   localparam int G_DEF     = 4;
   localparam int CNT_W_DEF = 10;

   typedef enum logic {FRAME_IDLE, FRAME_ACCUM} frame_state_t;

   function automatic int sign_idx(input int w);
      return w - 1;
   endfunction

   // Largest magnitude a w-bit sign-magnitude word can carry.
   function automatic longint unsigned sat_limit(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction
endpackage

// File: rtl/sm_accum_if.sv
// rtl/sm_accum_if.sv - beat input and frame result handshakes of sm_accum
interface sm_accum_if import sm_pkg::*; #(
   parameter int W     = W_DEF,
   parameter int CNT_W = CNT_W_DEF
) ();
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_data;
   logic             out_ovf;
   logic [CNT_W-1:0] out_count;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_ovf, out_count
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_ovf, out_count
   );
endinterface

// File: rtl/sm_add_core.sv
// rtl/sm_add_core.sv - combinational sign-magnitude adder with -0 normalisation
module sm_add_core import sm_pkg::*; #(
   parameter int N = W_DEF - 1 + G_DEF
) (
   input  logic         a_sign,
   input  logic [N-1:0] a_mag,
   input  logic         b_sign,
   input  logic [N-1:0] b_mag,
   output logic [N-1:0] sum_mag,
   output logic         sum_sign,
   output logic         carry
);
   logic [N:0] add_w;

   always_comb begin
      add_w    = {1'b0, a_mag} + {1'b0, b_mag};
      sum_mag  = '0;
      sum_sign = 1'b0;
      carry    = 1'b0;
      if (a_sign == b_sign) begin
         sum_mag  = add_w[N-1:0];
         sum_sign = a_sign;
         carry    = add_w[N];
      end else if (a_mag >= b_mag) begin
         sum_mag  = a_mag - b_mag;
         sum_sign = a_sign;
      end else begin
         sum_mag  = b_mag - a_mag;
         sum_sign = b_sign;
      end
      // A carried sum with zero low bits is a full-scale value, not zero.
      if (sum_mag == '0 && !carry) sum_sign = 1'b0;
   end
endmodule

// File: rtl/sm_accum.sv
// rtl/sm_accum.sv - framed sign-magnitude accumulator with saturation and beat count
module sm_accum import sm_pkg::*; #(
   parameter int W     = W_DEF,
   parameter int G     = G_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic      clk,
   input  logic      rst,
   sm_accum_if.slave bus
);
   localparam int SB = sign_idx(W);
   localparam int M  = W - 1 + G;
   localparam logic [M-1:0] LIM = M'(sat_limit(W));

   frame_state_t     state, state_nx;
   logic             s1_valid, s1_last, s1_sign;
   logic [W-2:0]     s1_mag;
   logic             acc_sign, ovf_s;
   logic [M-1:0]     acc_mag;
   logic [CNT_W-1:0] cnt;
   logic             stall, s2_adv, accept;
   logic [M-1:0]     sum_mag, nxt_mag;
   logic             sum_sign, carry;
   logic [W-2:0]     fin_mag;
   logic             fin_clamp;

   assign stall        = s1_valid && s1_last && bus.out_valid && !bus.out_ready;
   assign s2_adv       = s1_valid && !stall;
   assign bus.in_ready = !s1_valid || s2_adv;
   assign accept       = bus.in_valid && bus.in_ready;

   sm_add_core #(.N(M)) u_add (
      .a_sign   (acc_sign),
      .a_mag    (acc_mag),
      .b_sign   (s1_sign),
      .b_mag    ({{G{1'b0}}, s1_mag}),
      .sum_mag  (sum_mag),
      .sum_sign (sum_sign),
      .carry    (carry)
   );

   always_comb begin
      nxt_mag   = carry ? '1 : sum_mag;
      fin_clamp = nxt_mag > LIM;
      fin_mag   = fin_clamp ? LIM[W-2:0] : nxt_mag[W-2:0];
   end

   always_comb begin
      state_nx = state;
      case (state)
         FRAME_IDLE:  if (accept) state_nx = FRAME_ACCUM;
         FRAME_ACCUM: if (s2_adv && s1_last && !accept) state_nx = FRAME_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= FRAME_IDLE;
         s1_valid      <= 1'b0;
         s1_last       <= 1'b0;
         s1_sign       <= 1'b0;
         s1_mag        <= '0;
         acc_sign      <= 1'b0;
         acc_mag       <= '0;
         ovf_s         <= 1'b0;
         cnt           <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_ovf   <= 1'b0;
         bus.out_count <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            s1_valid <= 1'b1;
            s1_last  <= bus.in_last;
            s1_mag   <= bus.in_data[W-2:0];
            s1_sign  <= bus.in_data[SB] && (bus.in_data[W-2:0] != '0);
         end else if (s2_adv) begin
            s1_valid <= 1'b0;
         end

         if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;

         if (s2_adv) begin
            if (s1_last) begin
               acc_sign      <= 1'b0;
               acc_mag       <= '0;
               ovf_s         <= 1'b0;
               cnt           <= '0;
               bus.out_valid <= 1'b1;
               bus.out_data  <= {sum_sign, fin_mag};
               bus.out_ovf   <= ovf_s || carry || fin_clamp;
               bus.out_count <= cnt + CNT_W'(1);
            end else begin
               acc_sign <= sum_sign;
               acc_mag  <= nxt_mag;
               ovf_s    <= ovf_s || carry;
               cnt      <= cnt + CNT_W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_sm_accum.sv
// tb/tb_sm_accum.sv - directed and randomized checks of sm_accum against a frame-level model
module tb_sm_accum;
   import sm_pkg::*;

   localparam int W       = W_DEF;
   localparam int G       = G_DEF;
   localparam int CW      = 10;
   localparam int CW2     = 2;
   localparam int ACC_MAX = (1 << (W - 1 + G)) - 1;
   localparam int OUT_MAX = (1 << (W - 1)) - 1;

   typedef struct {
      logic [W-1:0] data;
      logic         ovf;
      int           n;
   } result_t;

   logic    clk = 1'b0;
   logic    rst;
   int      checks = 0;
   int      errors = 0;
   result_t expq[$];
   result_t r;
   int      m_acc = 0;
   logic    m_ovf = 1'b0;
   int      m_n = 0;
   int      f;

   sm_accum_if #(.W(W), .CNT_W(CW))  bus  ();
   sm_accum_if #(.W(W), .CNT_W(CW2)) bus2 ();

   assign bus2.in_valid  = bus.in_valid;
   assign bus2.in_data   = bus.in_data;
   assign bus2.in_last   = bus.in_last;
   assign bus2.out_ready = bus.out_ready;

   sm_accum #(.W(W), .G(G), .CNT_W(CW))  dut  (.clk(clk), .rst(rst), .bus(bus.slave));
   sm_accum #(.W(W), .G(G), .CNT_W(CW2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int sm_to_int(input logic [W-1:0] d);
      return d[W-1] ? -int'(d[W-2:0]) : int'(d[W-2:0]);
   endfunction

   function automatic logic [W-1:0] int_to_sm(input int v);
      return (v < 0) ? {1'b1, (W-1)'(-v)} : {1'b0, (W-1)'(v)};
   endfunction

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] v;
      v = W'($urandom);
      case ($urandom_range(0, 7))
         0: v[W-2:0] = '0;
         1: v[W-2:0] = '1;
         2: v[W-2:0] = (W-1)'($urandom_range(0, 3));
         default: ;
      endcase
      return v;
   endfunction

   // Frame-level reference: integer running sum saturated at the accumulator range.
   always @(negedge clk) begin
      if (rst) begin
         expq.delete();
         m_acc = 0;
         m_ovf = 1'b0;
         m_n   = 0;
      end else begin
         if (bus.out_valid) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: out_data 0x%0h with no frame pending", bus.out_data);
            end else begin
               check("model_data",      bus.out_data,   expq[0].data);
               check("model_ovf",       bus.out_ovf,    expq[0].ovf);
               check("model_count",     bus.out_count,  expq[0].n % (1 << CW));
               check("model_valid_cw2", bus2.out_valid, 1);
               check("model_data_cw2",  bus2.out_data,  expq[0].data);
               check("model_count_cw2", bus2.out_count, expq[0].n % (1 << CW2));
               if (bus.out_ready) void'(expq.pop_front());
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            m_acc += sm_to_int(bus.in_data);
            m_n++;
            if (m_acc > ACC_MAX) begin
               m_acc = ACC_MAX;
               m_ovf = 1'b1;
            end else if (m_acc < -ACC_MAX) begin
               m_acc = -ACC_MAX;
               m_ovf = 1'b1;
            end
            if (bus.in_last) begin
               f     = m_acc;
               r.ovf = m_ovf;
               if (f > OUT_MAX) begin
                  f     = OUT_MAX;
                  r.ovf = 1'b1;
               end else if (f < -OUT_MAX) begin
                  f     = -OUT_MAX;
                  r.ovf = 1'b1;
               end
               r.data = int_to_sm(f);
               r.n    = m_n;
               expq.push_back(r);
               m_acc = 0;
               m_ovf = 1'b0;
               m_n   = 0;
            end
         end
      end
   end

   task automatic send(input logic [W-1:0] d, input logic l);
      int t = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = l;
      @(negedge clk);
      while (!bus.in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: beat 0x%0h not accepted in 200 cycles", d);
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic expect_out(input string name, input logic [W-1:0] d, input logic o, input int n);
      int t = 0;
      @(negedge clk);
      while (!(bus.out_valid && bus.out_ready) && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!(bus.out_valid && bus.out_ready)) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: no result within 50 cycles", name);
      end else begin
         check({name, "_data"},      bus.out_data,   d);
         check({name, "_ovf"},       bus.out_ovf,    o);
         check({name, "_count"},     bus.out_count,  n % (1 << CW));
         check({name, "_count_cw2"}, bus2.out_count, n % (1 << CW2));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_out_valid", bus.out_valid, 0);
      check("reset_out_data",  bus.out_data,  0);
      check("reset_out_ovf",   bus.out_ovf,   0);
      check("reset_out_count", bus.out_count, 0);
      check("reset_in_ready",  bus.in_ready,  1);

      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      send(16'h0005, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h8003;
      bus.in_last  = 1'b1;
      @(negedge clk);
      check("lat_in_ready", bus.in_ready,  1);
      check("lat_valid_c0", bus.out_valid, 0);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      check("lat_valid_c1", bus.out_valid, 0);
      @(negedge clk);
      check("lat_valid_c2", bus.out_valid, 1);
      check("lat_data",     bus.out_data,  16'h0002);
      check("lat_ovf",      bus.out_ovf,   0);
      check("lat_count",    bus.out_count, 2);
      @(posedge clk);
      #1;

      send(16'h0003, 1'b0);
      send(16'h8003, 1'b1);
      expect_out("cancel", 16'h0000, 1'b0, 2);
      send(16'h8000, 1'b1);
      expect_out("neg_zero", 16'h0000, 1'b0, 1);

      repeat (3) send(16'h7FFF, 1'b0);
      send(16'h8000, 1'b1);
      expect_out("final_clamp", 16'h7FFF, 1'b1, 4);
      send(16'h8001, 1'b0);
      send(16'h8002, 1'b1);
      expect_out("neg_sum", 16'h8003, 1'b0, 2);

      // Accumulator saturates mid-frame; the later negative beats pull it back into range.
      repeat (17) send(16'h7FFF, 1'b0);
      repeat (15) send(16'hFFFF, 1'b0);
      send(16'hFFFF, 1'b1);
      expect_out("acc_sat", 16'h000F, 1'b1, 33);

      bus.out_ready = 1'b0;
      send(16'h0001, 1'b1);
      send(16'h0002, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_valid",    bus.out_valid, 1);
         check("stall_data",     bus.out_data,  16'h0001);
         check("stall_in_ready", bus.in_ready,  0);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      expect_out("stall_first",  16'h0001, 1'b0, 1);
      expect_out("stall_second", 16'h0002, 1'b0, 1);

      send(16'h0010, 1'b0);
      send(16'h0010, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      send(16'h0004, 1'b1);
      expect_out("after_reset", 16'h0004, 1'b0, 1);

      repeat (4) send(16'h0001, 1'b0);
      send(16'h0001, 1'b1);
      expect_out("count_wrap", 16'h0005, 1'b0, 5);

      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         #1;
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_data   = rand_word();
         bus.in_last   = ($urandom_range(0, 4) == 0);
      end
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (10) @(negedge clk);
      check("drain_queue_empty", expq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end
endmodule

// File: doc/sm_accum.md
SM_ACCUM -- requirements
Module: sm_accum

Interface
REQ-001 The block SHALL take parameter W, default 16, the sign-magnitude word width: bit W-1 is the sign, bits W-2:0 are the magnitude.
REQ-002 The block SHALL take parameter G, default 4, the number of accumulator guard bits above the W-1 magnitude bits.
REQ-003 The block SHALL take parameter CNT_W, default 10, the width of the beat counter.
REQ-004 clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  the input beat is valid.
REQ-007 in_ready  output  1  the block accepts a beat on any edge where in_valid and in_ready are both high.
REQ-008 in_data  input  W  the sign-magnitude operand.
REQ-009 in_last  input  1  marks the final beat of a frame.
REQ-010 out_valid  output  1  the frame result is available.
REQ-011 out_ready  input  1  the consumer accepts the result on any edge where out_valid and out_ready are both high.
REQ-012 out_data  output  W  the saturated sign-magnitude frame sum.
REQ-013 out_ovf  output  1  the frame saturated, either during accumulation or at the final clamp.
REQ-014 out_count  output  CNT_W  the number of beats in the frame, wrapping modulo 2^CNT_W.

Function
REQ-015 Pipeline: stage S1 SHALL register each accepted beat (data, last) together with s1_valid; stage S2 SHALL add the S1 operand into the accumulator ACC (sign plus W-1+G magnitude bits).
REQ-016 Signed addition: equal signs add magnitudes; unequal signs subtract the smaller magnitude from the larger and take the sign of the larger operand; equal magnitudes with opposite signs give +0.
REQ-017 Any zero magnitude SHALL carry sign 0: the block SHALL never emit or store -0 (0x8000 for W=16).
REQ-018 If the ACC magnitude carries out of W-1+G bits, ACC magnitude SHALL clamp to all-ones, keep its sign, and set the sticky flag ovf_s.
REQ-019 Each S2 advance SHALL increment cnt by 1, wrapping modulo 2^CNT_W.
REQ-020 Finalisation on an S2 advance with s1_last=1:
 - out_data <= sign plus magnitude clamped to 2^(W-1)-1.
 - out_ovf <= ovf_s OR the final clamp was applied.
 - out_count <= cnt+1.
 - out_valid <= 1.
 - ACC, cnt and ovf_s <= 0.
REQ-021 Latency: out_valid SHALL rise exactly 2 edges after the last beat is accepted, given no stall.
REQ-022 Stall: S2 SHALL NOT advance while s1_last=1 AND out_valid=1 AND out_ready=0.
REQ-023 in_ready SHALL equal !s1_valid OR S2-advance; it is combinational and contains no path from in_valid.
REQ-024 On an edge where out_valid and out_ready are both high and no new finalisation occurs, out_valid SHALL go to 0.
REQ-025 If a new finalisation coincides with result acceptance, the outputs SHALL load the new result and out_valid SHALL stay 1.
REQ-026 Frame state: IDLE (cnt=0 and S1 empty) -> ACCUM on the first accepted beat; ACCUM -> IDLE on finalisation.
REQ-027 A frame of one beat SHALL be legal; out_data then equals in_data, with -0 normalised to +0.
REQ-028 A beat may be accepted on the same edge that finalisation occurs; that beat starts the next frame.

Reset
REQ-029 While rst is high, on each edge the block SHALL clear s1_valid, ACC, cnt, ovf_s, out_valid, out_data, out_ovf and out_count to 0.
REQ-030 in_ready SHALL read 1 in the cycle after reset.
REQ-031 A reset mid-frame SHALL discard the partial frame and produce no output for it.

Structure
REQ-032 A shared package sm_pkg SHALL hold the default W, G and CNT_W, the sign-bit index helper, and the saturation-limit constant function.
REQ-033 Signed addition SHALL live in one combinational sub-module, sm_add_core, parameterised by width, which outputs sum, sign and carry-out with -0 normalisation.
REQ-034 sm_accum SHALL instantiate sm_add_core once, for the S2 addition.

Verification (W=16, G=4)
REQ-035 Beats 0x0005 then 0x8003 (last), out_ready=1 -> out_data=0x0002, out_ovf=0, out_count=2; out_valid rises 2 edges after the last beat is accepted.
REQ-036 Beats 0x0003 then 0x8003 (last) -> out_data=0x0000 (not 0x8000), out_count=2; a single beat 0x8000 (last) -> out_data=0x0000.
REQ-037 Three beats of 0x7FFF, then 0x8000 (last) -> out_data=0x7FFF, out_ovf=1; 0x8001 + 0x8002 (last) -> out_data=0x8003, out_ovf=0.
REQ-038 Two back-to-back single-beat frames 0x0001 and 0x0002 with out_ready=0 for 5 cycles -> result 0x0001 holds stable, in_ready drops, no beat is lost; after out_ready rises the results arrive in the order 0x0001 then 0x0002.
REQ-039 Reset asserted after 2 beats of a frame (0x0010, 0x0010) -> no output for that frame; the following frame 0x0004 (last) -> out_data=0x0004, out_count=1.
REQ-040 CNT_W=2, a frame of 5 beats of 0x0001 -> out_count=1 (wrapped), out_data=0x0005.
